register_strobe_sequencer: RTL and testbench



---
 rtl/register_strobe_sequencer_pkg.sv | 68 ++++++
 rtl/register_strobe_sequencer_if.sv | 29 ++
 rtl/register_strobe_sequencer_strobe_decode.sv | 76 +++++++
 rtl/register_strobe_sequencer.sv | 131 +++++++++++++
 tb/tb_register_strobe_sequencer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/register_strobe_sequencer_pkg.sv
// Shared encodings for the register strobe sequencer: opcodes, ALU ops,
// the T-state enum and the packed strobe bundle.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'h00;
  localparam logic [4:0] OP_LDI  = 5'h01;
  localparam logic [4:0] OP_ST   = 5'h02;
  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SUB  = 5'h04;
  localparam logic [4:0] OP_AND  = 5'h05;
  localparam logic [4:0] OP_OR   = 5'h06;
  localparam logic [4:0] OP_ADDI = 5'h0C;
  localparam logic [4:0] OP_ANDI = 5'h0D;
  localparam logic [4:0] OP_ORI  = 5'h0E;
  localparam logic [4:0] OP_NOP  = 5'h1A;
  localparam logic [4:0] OP_HALT = 5'h1B;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED
  } state_t;

  typedef struct packed {
    logic Gra;
    logic Grb;
    logic Grc;
    logic Rin;
    logic Rout;
    logic BAout;
    logic PCout;
    logic PCin;
    logic IncPC;
    logic MARin;
    logic MDRin;
    logic MDRout;
    logic IRin;
    logic Yin;
    logic Zin;
    logic Zlowout;
    logic Cout;
    logic Read;
    logic Write;
  } strobe_t;

  // ALU operation implied by an opcode; address arithmetic uses ADD
  function automatic logic [3:0] alu_for(input logic [4:0] op);
    case (op)
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR,  OP_ORI:  return ALU_OR;
      default:         return ALU_ADD;
    endcase
  endfunction

  // True for every opcode the sequencer knows how to run
  function automatic logic op_listed(input logic [4:0] op);
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI, OP_NOP, OP_HALT: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/register_strobe_sequencer_if.sv
// Bus between the sequencer (master: drives strobes) and the
// IR / memory / datapath side (slave: drives run, ir, mem_ready).
interface register_strobe_sequencer_if;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;
  logic        Gra, Grb, Grc;
  logic        Rin, Rout, BAout;
  logic        PCout, PCin, IncPC;
  logic        MARin, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Cout;
  logic        Read, Write;
  logic [3:0]  alu_op;
  logic        halted, illegal;

  modport master (
    input  run, ir, mem_ready,
    output Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC,
           MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout,
           Read, Write, alu_op, halted, illegal
  );

  modport slave (
    output run, ir, mem_ready,
    input  Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC,
           MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout,
           Read, Write, alu_op, halted, illegal
  );
endinterface

// File: rtl/register_strobe_sequencer_strobe_decode.sv
// Combinational map from (next T-state, opcode) to the strobe bundle and
// alu_op. alu_op is only non-ADD in T4, where the ALU actually operates.
module strobe_decode
  import cpu_pkg::*;
(
  input  state_t     nxt_state,
  input  logic [4:0] op,
  output strobe_t    stb,
  output logic [3:0] alu_op
);

  logic is_rr, is_imm, is_ldi, is_ld, is_st, is_mem;

  assign is_rr  = (op == OP_ADD) | (op == OP_SUB) | (op == OP_AND) | (op == OP_OR);
  assign is_imm = (op == OP_ADDI) | (op == OP_ANDI) | (op == OP_ORI);
  assign is_ldi = (op == OP_LDI);
  assign is_ld  = (op == OP_LD);
  assign is_st  = (op == OP_ST);
  assign is_mem = is_ld | is_st;

  // Strobe pattern for each T-state of each instruction class
  always_comb begin
    stb    = '0;
    alu_op = ALU_ADD;
    case (nxt_state)
      S_T0: begin
        stb.PCout = 1'b1; stb.MARin = 1'b1; stb.IncPC = 1'b1; stb.Zin = 1'b1;
      end
      S_T1: begin
        stb.Zlowout = 1'b1; stb.PCin = 1'b1; stb.Read = 1'b1; stb.MDRin = 1'b1;
      end
      S_T2: begin
        stb.MDRout = 1'b1; stb.IRin = 1'b1;
      end
      S_T3: begin
        if (is_rr || is_imm) begin
          stb.Grb = 1'b1; stb.Rout = 1'b1; stb.Yin = 1'b1;
        end else if (is_ldi || is_mem) begin
          stb.Grb = 1'b1; stb.BAout = 1'b1; stb.Yin = 1'b1;
        end
      end
      S_T4: begin
        if (is_rr) begin
          stb.Grc = 1'b1; stb.Rout = 1'b1; stb.Zin = 1'b1;
          alu_op  = alu_for(op);
        end else if (is_imm || is_ldi || is_mem) begin
          stb.Cout = 1'b1; stb.Zin = 1'b1;
          alu_op   = alu_for(op);
        end
      end
      S_T5: begin
        if (is_rr || is_imm || is_ldi) begin
          stb.Zlowout = 1'b1; stb.Gra = 1'b1; stb.Rin = 1'b1;
        end else if (is_mem) begin
          stb.Zlowout = 1'b1; stb.MARin = 1'b1;
        end
      end
      S_T6: begin
        if (is_ld) begin
          stb.Read = 1'b1; stb.MDRin = 1'b1;
        end else if (is_st) begin
          stb.Gra = 1'b1; stb.Rout = 1'b1; stb.MDRin = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          stb.MDRout = 1'b1; stb.Gra = 1'b1; stb.Rin = 1'b1;
        end else if (is_st) begin
          stb.Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/register_strobe_sequencer.sv
// Control-unit sequencer: fetch (T0-T2) and execute (T3-T7) T-states,
// with memory stalls in T1, T6 (LD) and T7 (ST). All outputs are flops
// loaded from the decode of the next state.
// Build option: REGISTER_STROBE_SEQUENCER_ILLEGAL_TRAP_EN makes an unlisted
// opcode halt with illegal=1; otherwise it runs as a NOP.
module register_strobe_sequencer
  import cpu_pkg::*;
(
  input  logic                       clock,
  input  logic                       clear_n,
  register_strobe_sequencer_if.master bus
);

  state_t     state, nxt;
  logic [4:0] op_q, op_dec;
  strobe_t    stb_d, stb_q;
  logic [3:0] alu_d, alu_q;
  logic       halted_q;
  logic       listed, trap, nop_like, fin_run;
  state_t     fin;
  logic       unused_ir;

  assign unused_ir = ^bus.ir[26:0];

  // The opcode is taken live from ir while leaving T2, latched afterwards
  assign op_dec  = (state == S_T2) ? bus.ir[31:27] : op_q;
  assign listed  = op_listed(op_dec);
`ifdef REGISTER_STROBE_SEQUENCER_ILLEGAL_TRAP_EN
  assign trap    = ~listed;
`else
  assign trap    = 1'b0;
`endif
  assign nop_like = (op_dec == OP_NOP) | (~listed & ~trap);
  assign fin_run  = bus.run;
  assign fin      = fin_run ? S_T0 : S_IDLE;

  // Next-state: fetch, per-class execute length, memory stalls
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (bus.run) nxt = S_T0;
      S_T0:   nxt = S_T1;
      S_T1:   if (bus.mem_ready) nxt = S_T2;
      S_T2: begin
        if (op_dec == OP_HALT || trap) nxt = S_HALTED;
        else if (nop_like)             nxt = fin;
        else                           nxt = S_T3;
      end
      S_T3:   nxt = S_T4;
      S_T4:   nxt = S_T5;
      S_T5:   nxt = (op_q == OP_LD || op_q == OP_ST) ? S_T6 : fin;
      S_T6: begin
        if (op_q == OP_LD) begin
          if (bus.mem_ready) nxt = S_T7;
        end else begin
          nxt = S_T7;
        end
      end
      S_T7: begin
        if (op_q == OP_ST) begin
          if (bus.mem_ready) nxt = fin;
        end else begin
          nxt = fin;
        end
      end
      S_HALTED: nxt = S_HALTED;
      default:  nxt = S_IDLE;
    endcase
  end

  strobe_decode u_decode (
    .nxt_state (nxt),
    .op        (op_dec),
    .stb       (stb_d),
    .alu_op    (alu_d)
  );

  // State, opcode latch and registered strobes
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      stb_q    <= '0;
      alu_q    <= ALU_ADD;
      halted_q <= 1'b0;
    end else begin
      state    <= nxt;
      stb_q    <= stb_d;
      alu_q    <= alu_d;
      halted_q <= (nxt == S_HALTED);
      if (state == S_T2) op_q <= bus.ir[31:27];
    end
  end

`ifdef REGISTER_STROBE_SEQUENCER_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky flag set when an unlisted opcode halts the sequencer
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)                   illegal_q <= 1'b0;
    else if (state == S_T2 && trap) illegal_q <= 1'b1;
  end

  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.Gra     = stb_q.Gra;
  assign bus.Grb     = stb_q.Grb;
  assign bus.Grc     = stb_q.Grc;
  assign bus.Rin     = stb_q.Rin;
  assign bus.Rout    = stb_q.Rout;
  assign bus.BAout   = stb_q.BAout;
  assign bus.PCout   = stb_q.PCout;
  assign bus.PCin    = stb_q.PCin;
  assign bus.IncPC   = stb_q.IncPC;
  assign bus.MARin   = stb_q.MARin;
  assign bus.MDRin   = stb_q.MDRin;
  assign bus.MDRout  = stb_q.MDRout;
  assign bus.IRin    = stb_q.IRin;
  assign bus.Yin     = stb_q.Yin;
  assign bus.Zin     = stb_q.Zin;
  assign bus.Zlowout = stb_q.Zlowout;
  assign bus.Cout    = stb_q.Cout;
  assign bus.Read    = stb_q.Read;
  assign bus.Write   = stb_q.Write;
  assign bus.alu_op  = alu_q;
  assign bus.halted  = halted_q;

endmodule

// File: tb/tb_register_strobe_sequencer.sv
// Scoreboard bench: the driver pushes the expected output vector for each
// cycle; the monitor pops and compares on every falling clock edge and
// shortly after an asynchronous reset assertion.
module tb_register_strobe_sequencer;

  typedef logic [24:0] obs_t;

  localparam obs_t GRA    = obs_t'(1) << 24;
  localparam obs_t GRB    = obs_t'(1) << 23;
  localparam obs_t GRC    = obs_t'(1) << 22;
  localparam obs_t RIN    = obs_t'(1) << 21;
  localparam obs_t ROUT   = obs_t'(1) << 20;
  localparam obs_t BAOUT  = obs_t'(1) << 19;
  localparam obs_t PCOUT  = obs_t'(1) << 18;
  localparam obs_t PCIN   = obs_t'(1) << 17;
  localparam obs_t INCPC  = obs_t'(1) << 16;
  localparam obs_t MARIN  = obs_t'(1) << 15;
  localparam obs_t MDRIN  = obs_t'(1) << 14;
  localparam obs_t MDROUT = obs_t'(1) << 13;
  localparam obs_t IRIN   = obs_t'(1) << 12;
  localparam obs_t YIN    = obs_t'(1) << 11;
  localparam obs_t ZIN    = obs_t'(1) << 10;
  localparam obs_t ZLOW   = obs_t'(1) << 9;
  localparam obs_t COUT   = obs_t'(1) << 8;
  localparam obs_t READ   = obs_t'(1) << 7;
  localparam obs_t WRITE  = obs_t'(1) << 6;
  localparam obs_t HLT    = obs_t'(1) << 1;
  localparam obs_t ILL    = obs_t'(1) << 0;
  localparam obs_t ALU_S  = obs_t'(1) << 2;
  localparam obs_t ALU_O  = obs_t'(3) << 2;

  localparam obs_t F0 = PCOUT | MARIN | INCPC | ZIN;
  localparam obs_t F1 = ZLOW | PCIN | READ | MDRIN;
  localparam obs_t F2 = MDROUT | IRIN;

  logic clock = 1'b0;
  logic clear_n;
  always #5 clock = ~clock;

  register_strobe_sequencer_if bus();

  register_strobe_sequencer dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  obs_t exp_q[$];
  int   tag_q[$];
  int   total = 0;
  int   bad   = 0;
  int   step  = 0;

  task automatic push(input obs_t e);
    exp_q.push_back(e);
    tag_q.push_back(step);
    step++;
  endtask

  // Set inputs for the next edge, then expect e for the cycle it starts
  task automatic tick(input bit r, input logic [4:0] op, input bit m, input obs_t e);
    bus.run       = r;
    bus.ir        = {op, 4'd1, 4'd2, 4'd3, 15'd0};
    bus.mem_ready = m;
    @(posedge clock);
    #1;
    push(e);
  endtask

  // Assert clear_n mid-cycle (after the falling edge), hold across one edge
  task automatic pulse_reset();
    @(negedge clock);
    #2;
    push('0);
    clear_n = 1'b0;
    @(posedge clock);
    #1;
    push('0);
    clear_n = 1'b1;
  endtask

  // Monitor: compare outputs against the scoreboard and check invariants
  always begin
    obs_t o, e;
    int   t;
    @(negedge clock or negedge clear_n);
    #1;
    o = {bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.PCout,
         bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout, bus.IRin,
         bus.Yin, bus.Zin, bus.Zlowout, bus.Cout, bus.Read, bus.Write,
         bus.alu_op, bus.halted, bus.illegal};
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL step%0d outputs got=%h want=%h", t, o, e);
      end
    end
    total++;
    if (($countones({bus.Gra, bus.Grb, bus.Grc}) > 1) ||
        (bus.Rin && bus.Rout) || (bus.Read && bus.Write)) begin
      bad++;
      $display("FAIL invariant outputs got=%h want=exclusive selects", o);
    end
  end

  initial begin
    clear_n       = 1'b0;
    bus.run       = 1'b0;
    bus.ir        = '0;
    bus.mem_ready = 1'b1;
    @(posedge clock); #1; push('0);
    @(posedge clock); #1; push('0);
    clear_n = 1'b1;

    // ADD r1,r2,r3
    tick(1, 5'h03, 1, F0);
    tick(1, 5'h03, 1, F1);
    tick(1, 5'h03, 1, F2);
    tick(1, 5'h03, 1, GRB | ROUT | YIN);
    tick(1, 5'h03, 1, GRC | ROUT | ZIN);
    tick(1, 5'h03, 1, ZLOW | GRA | RIN);

    // LD, back-to-back, 3-cycle stall in T6
    tick(1, 5'h00, 1, F0);
    tick(1, 5'h00, 1, F1);
    tick(1, 5'h00, 1, F2);
    tick(1, 5'h00, 1, GRB | BAOUT | YIN);
    tick(1, 5'h00, 1, COUT | ZIN);
    tick(1, 5'h00, 1, ZLOW | MARIN);
    tick(1, 5'h00, 1, READ | MDRIN);
    for (int i = 0; i < 3; i++) tick(1, 5'h00, 0, READ | MDRIN);
    tick(1, 5'h00, 1, MDROUT | GRA | RIN);

    // ST, 1-cycle stall in T1 and in T7; T6 must not stall
    tick(1, 5'h02, 1, F0);
    tick(1, 5'h02, 1, F1);
    tick(1, 5'h02, 0, F1);
    tick(1, 5'h02, 1, F2);
    tick(1, 5'h02, 1, GRB | BAOUT | YIN);
    tick(1, 5'h02, 1, COUT | ZIN);
    tick(1, 5'h02, 1, ZLOW | MARIN);
    tick(1, 5'h02, 1, GRA | ROUT | MDRIN);
    tick(1, 5'h02, 0, WRITE);
    tick(1, 5'h02, 0, WRITE);

    // ORI; ir changes to HALT after T3 and must be ignored
    tick(1, 5'h0E, 1, F0);
    tick(1, 5'h0E, 1, F1);
    tick(1, 5'h0E, 1, F2);
    tick(1, 5'h0E, 1, GRB | ROUT | YIN);
    tick(1, 5'h1B, 1, COUT | ZIN | ALU_O);
    tick(1, 5'h1B, 1, ZLOW | GRA | RIN);

    // NOP then SUB, reset asserted in SUB's T4
    tick(1, 5'h1A, 1, F0);
    tick(1, 5'h1A, 1, F1);
    tick(1, 5'h1A, 1, F2);
    tick(1, 5'h1A, 1, F0);
    tick(1, 5'h04, 1, F1);
    tick(1, 5'h04, 1, F2);
    tick(1, 5'h04, 1, GRB | ROUT | YIN);
    tick(1, 5'h04, 1, GRC | ROUT | ZIN | ALU_S);
    pulse_reset();
    for (int i = 0; i < 3; i++) tick(0, 5'h04, 1, '0);

    // LDI with run dropped mid-instruction: finishes, then IDLE
    tick(1, 5'h01, 1, F0);
    tick(1, 5'h01, 1, F1);
    tick(1, 5'h01, 1, F2);
    tick(0, 5'h01, 1, GRB | BAOUT | YIN);
    tick(0, 5'h01, 1, COUT | ZIN);
    tick(0, 5'h01, 1, ZLOW | GRA | RIN);
    tick(0, 5'h01, 1, '0);
    tick(0, 5'h01, 1, '0);

    // Unlisted opcode 1Fh
    tick(1, 5'h1F, 1, F0);
    tick(1, 5'h1F, 1, F1);
    tick(1, 5'h1F, 1, F2);
`ifdef REGISTER_STROBE_SEQUENCER_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) tick(1, 5'h1F, 1, HLT | ILL);
`else
    tick(1, 5'h1F, 1, F0);
`endif
    pulse_reset();

    // HALT: no strobes for 20 cycles despite run=1
    tick(1, 5'h1B, 1, F0);
    tick(1, 5'h1B, 1, F1);
    tick(1, 5'h1B, 1, F2);
    for (int i = 0; i < 20; i++) tick(1, 5'h1B, 1, HLT);

    @(negedge clock);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
